// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, frame width and default line timing
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} rx_state_e;
    localparam int DATA_BITS = 8;
    localparam int DEF_CLK_FREQ = 50000000;
    localparam int DEF_BAUD = 9600;
endpackage

// File: rtl/rx_bps_module.sv
// rx_bps_module: per-bit baud timer for the UART receiver
// Ports: CLK clock; RST sync active-high reset; Count_Sig runs the counter (clears it when low);
//        Mid_Sig high while the count sits at the mid-bit point; End_Sig high on the last count of a bit
module rx_bps_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD = DEF_BAUD
) (
    input  logic CLK,
    input  logic RST,
    input  logic Count_Sig,
    output logic Mid_Sig,
    output logic End_Sig
);
    localparam int BPS_T = CLK_FREQ / BAUD;
    localparam int BPS_HALF = BPS_T / 2;
    logic [12:0] count_bps_q, count_bps_d;
    assign Mid_Sig = count_bps_q == 13'(BPS_HALF);
    assign End_Sig = count_bps_q == 13'(BPS_T - 1);
    always_comb count_bps_d = (Count_Sig && !End_Sig) ? count_bps_q + 13'd1 : 13'd0;
    always_ff @(posedge CLK) count_bps_q <= RST ? 13'd0 : count_bps_d;
endmodule

// File: rtl/uart_rx_module.sv
// uart_rx_module: 8N1 UART receiver with mid-bit sampling and stop-bit check
// Ports: CLK clock; RST sync active-high reset; RX_Pin_In async serial line (idle high);
//        RX_En_Sig frame enable; RX_Data last good byte; RX_Done_Sig one-cycle byte strobe;
//        Frame_Err_Sig one-cycle bad-stop strobe; Parity_Err_Sig one-cycle even-parity mismatch strobe
//        (present only when UART_RX_PARITY_EN is defined, which adds a parity bit before stop)
module uart_rx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD = DEF_BAUD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       Frame_Err_Sig
`ifdef UART_RX_PARITY_EN
    ,output logic      Parity_Err_Sig
`endif
);
    rx_state_e state_q, state_d;
    logic sync1_q, sync2_q, sync3_q;
    logic [2:0] idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic done_q, done_d, ferr_q, ferr_d;
    logic mid, bend, line, fall;
    assign line = sync2_q;
    assign fall = !sync2_q && sync3_q;
    rx_bps_module #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_bps (
        .CLK(CLK),
        .RST(RST),
        .Count_Sig(state_q != IDLE && state_q != WAIT_HI),
        .Mid_Sig(mid),
        .End_Sig(bend)
    );
`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d, pbad_q, pbad_d;
    assign Parity_Err_Sig = perr_q;
`endif
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        shift_d = shift_q;
        data_d = data_q;
        done_d = 1'b0;
        ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
        pbad_d = pbad_q;
`endif
        // losing enable abandons any frame in progress without strobes
        if (state_q != IDLE && !RX_En_Sig) state_d = IDLE;
        else case (state_q)
            IDLE: if (fall && RX_En_Sig) state_d = START;
            START: begin
                if (mid && line) state_d = IDLE;
                else if (bend) begin
                    state_d = DATA;
                    idx_d = 3'd0;
                end
            end
            DATA: begin
                if (mid) shift_d = {line, shift_q[DATA_BITS-1:1]};
                if (bend) begin
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
                    else idx_d = idx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid) begin
                    pbad_d = ^{shift_q, line};
                    perr_d = ^{shift_q, line};
                end
                if (bend) state_d = STOP;
            end
`endif
            // leave at mid-bit so a start edge right after the stop bit is seen
            STOP: if (mid) begin
                if (line) begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (!pbad_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end
`else
                    data_d = shift_q;
                    done_d = 1'b1;
`endif
                end else begin
                    ferr_d = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            // a held-low break must return high before a new start is accepted
            WAIT_HI: if (line) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            {sync1_q, sync2_q, sync3_q} <= 3'b111;
            idx_q <= 3'd0;
            shift_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
            pbad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            {sync1_q, sync2_q, sync3_q} <= {RX_Pin_In, sync1_q, sync2_q};
            idx_q <= idx_d;
            shift_q <= shift_d;
            data_q <= data_d;
            done_q <= done_d;
            ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q <= perr_d;
            pbad_q <= pbad_d;
`endif
        end
    end
    assign RX_Data = data_q;
    assign RX_Done_Sig = done_q;
    assign Frame_Err_Sig = ferr_q;
endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module: directed self-checking bench for uart_rx_module at 10 clocks per bit
module tb_uart_rx_module;
    localparam int BPS = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, rx_pin, rx_en;
    logic [7:0] rx_data;
    logic rx_done, frame_err;
    int vectors = 0, miscompares = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, bad_strobe = 0;
    logic done_prev = 1'b0, ferr_prev = 1'b0;
    logic [7:0] rx_log [$];
`ifdef UART_RX_PARITY_EN
    logic parity_err;
`endif

    uart_rx_module #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .CLK(clk),
        .RST(rst),
        .RX_Pin_In(rx_pin),
        .RX_En_Sig(rx_en),
        .RX_Data(rx_data),
        .RX_Done_Sig(rx_done),
        .Frame_Err_Sig(frame_err)
`ifdef UART_RX_PARITY_EN
        ,.Parity_Err_Sig(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            rx_log.push_back(rx_data);
        end
        if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt++;
`endif
        if ((rx_done && done_prev) || (frame_err && ferr_prev) || (rx_done && frame_err)) bad_strobe++;
        done_prev = rx_done;
        ferr_prev = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_pin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len, input logic flip);
        drive_bit(1'b0, BPS);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BPS);
        if (PAR) drive_bit(^b ^ flip, BPS);
        drive_bit(stop, stop_len);
    endtask

    initial begin
        rst = 1'b1;
        rx_pin = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", {24'd0, rx_data}, 32'h00);
        chk("reset_done", {31'd0, rx_done}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 5);

        send_frame(8'hA5, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("a5_done_cnt", done_cnt, 1);
        chk("a5_log", {24'd0, rx_log[0]}, 32'hA5);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_ferr", ferr_cnt, 0);

        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        chk("glitch_done", done_cnt, 1);
        chk("glitch_ferr", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("3c_done_cnt", done_cnt, 2);
        chk("3c_data", {24'd0, rx_data}, 32'h3C);

        send_frame(8'h3C, 1'b0, 20, 1'b0);
        drive_bit(1'b1, 15);
        chk("break_ferr", ferr_cnt, 1);
        chk("break_done", done_cnt, 2);
        chk("break_data", {24'd0, rx_data}, 32'h3C);
        send_frame(8'h0F, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("0f_done_cnt", done_cnt, 3);
        chk("0f_data", {24'd0, rx_data}, 32'h0F);
        chk("0f_ferr", ferr_cnt, 1);

        send_frame(8'h00, 1'b1, BPS, 1'b0);
        send_frame(8'hFF, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("b2b_done_cnt", done_cnt, 5);
        chk("b2b_first", {24'd0, rx_log[3]}, 32'h00);
        chk("b2b_second", {24'd0, rx_log[4]}, 32'hFF);

        drive_bit(1'b0, BPS);
        drive_bit(1'b0, BPS);
        drive_bit(1'b1, BPS);
        drive_bit(1'b0, BPS);
        drive_bit(1'b1, BPS);
        drive_bit(1'b1, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_data", {24'd0, rx_data}, 32'h00);
        chk("rst_mid_done", {31'd0, rx_done}, 32'd0);
        chk("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 100);
        chk("rst_no_done", done_cnt, 5);
        send_frame(8'h5A, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("5a_done_cnt", done_cnt, 6);
        chk("5a_data", {24'd0, rx_data}, 32'h5A);

        drive_bit(1'b0, BPS);
        drive_bit(1'b1, BPS);
        drive_bit(1'b0, BPS);
        rx_en = 1'b0;
        drive_bit(1'b1, 3);
        rx_en = 1'b1;
        drive_bit(1'b1, 120);
        chk("en_drop_done", done_cnt, 6);
        chk("en_drop_ferr", ferr_cnt, 1);
        chk("en_drop_data", {24'd0, rx_data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, BPS, 1'b0);
        drive_bit(1'b1, 5);
        chk("par_ok_done", done_cnt, 7);
        chk("par_ok_data", {24'd0, rx_data}, 32'h07);
        chk("par_ok_perr", perr_cnt, 0);
        send_frame(8'h07, 1'b1, BPS, 1'b1);
        drive_bit(1'b1, 5);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_done", done_cnt, 7);
`endif

        chk("strobe_width", bad_strobe, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
